wb_arbiter: RTL and testbench

Writeback arbiter that produces the completion stream the issue stage consumes. It collects results from the scalar functional units (ALU, scalar load/store, branch), buffers them per unit, and selects one result per cycle round-robin. It drives the register-write fields of `wb_t` plus `s_wdata`, and a per-unit done pulse the issue stage uses to clear FUST rows and `fust_state`. It also discards speculative results on a mispredict flush.

---
 rtl/wb_arbiter_pkg.sv | 32 +++
 rtl/wb_src_fifo.sv | 79 +++++++
 rtl/wb_arbiter.sv | 141 ++++++++++++++
 tb/tb_wb_arbiter.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_arbiter_pkg.sv
// Shared types for the writeback arbiter: source ids, per-source request
// payload and the registered writeback slot handed to the issue stage.
package wb_arbiter_pkg;

  localparam int unsigned WB_NSRC = 3;
  localparam int unsigned WB_SW   = $clog2(WB_NSRC);
  localparam int unsigned WB_RW   = 5;
  localparam int unsigned WB_DW   = 32;

  typedef enum logic [WB_SW-1:0] {
    WB_SRC_ALU  = 2'd0,
    WB_SRC_LDST = 2'd1,
    WB_SRC_BR   = 2'd2
  } wb_src_e;

  typedef struct packed {
    logic             wen;
    logic [WB_RW-1:0] rd;
    logic [WB_DW-1:0] wdata;
    logic             spec;
  } wb_req_t;

  typedef struct packed {
    logic               valid;
    logic [WB_SW-1:0]   src;
    logic               reg_en;
    logic [WB_RW-1:0]   rd;
    logic [WB_DW-1:0]   wdata;
    logic [WB_NSRC-1:0] done;
  } wb_t;

endpackage

// File: rtl/wb_src_fifo.sv
// Per-source result FIFO with speculative-tail truncation on flush and a
// clear-all-spec port for correctly resolved branches.
module wb_src_fifo
  import wb_arbiter_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic    clk,
  input  logic    rst,
  input  logic    push_valid,
  input  wb_req_t push,
  input  logic    pop,
  input  logic    flush,
  input  logic    clear_spec,
  output logic    ready_c,
  output logic    empty_c,
  output wb_req_t head_c
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  wb_req_t        mem [DEPTH];
  logic [PW-1:0]  rd_ptr;
  logic [CW-1:0]  count;
  logic [CW-1:0]  keep_c;
  logic [CW-1:0]  base_c;
  logic [PW-1:0]  wr_idx_c;
  logic           full_c;
  logic           enq_c;
  logic           run;
  logic           clr_c;

  assign full_c   = (count == CW'(DEPTH));
  assign ready_c  = !full_c && !rst;
  assign empty_c  = (count == '0);
  assign head_c   = mem[rd_ptr];
  // A spec result arriving during a flush is accepted but discarded.
  assign enq_c    = push_valid && ready_c && !(flush && push.spec);
  assign clr_c    = clear_spec && !flush;
  assign base_c   = flush ? keep_c : count;
  assign wr_idx_c = rd_ptr + PW'(base_c);

  // Length of the leading non-spec run; spec entries are always the youngest.
  always_comb begin
    keep_c = '0;
    run    = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      if (run && (CW'(i) < count) && !mem[rd_ptr + PW'(i)].spec) begin
        keep_c = keep_c + CW'(1);
      end else begin
        run = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      rd_ptr <= rd_ptr + PW'(pop);
      count  <= base_c + CW'(enq_c) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      if (clr_c) begin
        for (int i = 0; i < DEPTH; i++) mem[i].spec <= 1'b0;
      end
      if (enq_c) begin
        mem[wr_idx_c]      <= push;
        mem[wr_idx_c].spec <= push.spec && !clear_spec;
      end
    end
  end

endmodule

// File: rtl/wb_arbiter.sv
// Round-robin writeback arbiter: buffers scalar FU results per source and
// presents one registered writeback per cycle to the issue stage.
module wb_arbiter
  import wb_arbiter_pkg::*;
#(
  parameter int unsigned NSRC  = WB_NSRC,
  parameter int unsigned DEPTH = 2,
  parameter int unsigned RW    = WB_RW,
  parameter int unsigned DW    = WB_DW,
  localparam int unsigned SW   = (NSRC > 1) ? $clog2(NSRC) : 1
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic [NSRC-1:0]         src_valid,
  output logic [NSRC-1:0]         src_ready,
  input  logic [NSRC-1:0]         src_wen,
  input  logic [NSRC-1:0][RW-1:0] src_rd,
  input  logic [NSRC-1:0][DW-1:0] src_wdata,
  input  logic [NSRC-1:0]         src_spec,
  input  logic                    flush,
  input  logic                    branch_resolved,
  input  logic                    freeze,
  output logic                    wb_valid,
  output logic [SW-1:0]           wb_src,
  output logic                    wb_reg_en,
  output logic [RW-1:0]           wb_rd,
  output logic [DW-1:0]           s_wdata,
  output logic [NSRC-1:0]         fu_done
);

  wb_req_t         push_req [NSRC];
  wb_req_t         head     [NSRC];
  wb_req_t         head_g;
  logic [NSRC-1:0] empty_c;
  logic [NSRC-1:0] pop_c;
  logic [SW-1:0]   ptr;
  logic [SW-1:0]   ptr_nxt_c;
  logic [SW-1:0]   grant_c;
  logic            any_c;
  logic            load_c;
  logic            clr_c;
  int              idx;
  wb_t             wb_q;
  wb_t             wb_d;
  logic            spec_q;
  logic            spec_d;

  for (genvar i = 0; i < NSRC; i++) begin : g_src
    assign push_req[i] = wb_req_t'{
      wen:   src_wen[i],
      rd:    WB_RW'(src_rd[i]),
      wdata: WB_DW'(src_wdata[i]),
      spec:  src_spec[i]
    };

    wb_src_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk        (CLK),
      .rst        (RST),
      .push_valid (src_valid[i]),
      .push       (push_req[i]),
      .pop        (pop_c[i]),
      .flush      (flush),
      .clear_spec (branch_resolved),
      .ready_c    (src_ready[i]),
      .empty_c    (empty_c[i]),
      .head_c     (head[i])
    );
  end

  // First non-empty source at or after the round-robin pointer.
  always_comb begin
    any_c   = 1'b0;
    grant_c = '0;
    idx     = 0;
    for (int k = 0; k < NSRC; k++) begin
      idx = (int'(ptr) + k) % int'(NSRC);
      if (!any_c && !empty_c[SW'(idx)]) begin
        any_c   = 1'b1;
        grant_c = SW'(idx);
      end
    end
  end

  assign ptr_nxt_c = (grant_c == SW'(NSRC - 1)) ? '0 : grant_c + SW'(1);
  assign head_g    = head[grant_c];

  // Output slot next-state: flush > freeze > new grant > clear.
  always_comb begin
    wb_d   = wb_q;
    spec_d = spec_q;
    load_c = 1'b0;
    clr_c  = 1'b0;
    if (flush) begin
      clr_c = !(freeze && wb_q.valid && !spec_q);
    end else if (freeze) begin
      if (branch_resolved) spec_d = 1'b0;
    end else if (any_c) begin
      load_c = 1'b1;
    end else begin
      clr_c = 1'b1;
    end
    if (clr_c) begin
      wb_d   = '0;
      spec_d = 1'b0;
    end
    if (load_c) begin
      wb_d.valid  = 1'b1;
      wb_d.src    = WB_SW'(grant_c);
      wb_d.reg_en = head_g.wen;
      wb_d.rd     = head_g.rd;
      wb_d.wdata  = head_g.wdata;
      wb_d.done   = WB_NSRC'(1) << grant_c;
      spec_d      = head_g.spec && !branch_resolved;
    end
  end

  always_comb begin
    pop_c = '0;
    if (load_c) pop_c[grant_c] = 1'b1;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      wb_q   <= '0;
      spec_q <= 1'b0;
      ptr    <= '0;
    end else begin
      wb_q   <= wb_d;
      spec_q <= spec_d;
      if (load_c) ptr <= ptr_nxt_c;
    end
  end

  assign wb_valid  = wb_q.valid;
  assign wb_src    = SW'(wb_q.src);
  assign wb_reg_en = wb_q.reg_en;
  assign wb_rd     = RW'(wb_q.rd);
  assign s_wdata   = DW'(wb_q.wdata);
  assign fu_done   = NSRC'(wb_q.done);

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter: reset, latency, round-robin contention,
// freeze, flush, branch resolution and mid-stream reset.
module tb_wb_arbiter;

  logic             CLK;
  logic             RST;
  logic [2:0]       src_valid;
  logic [2:0]       src_ready;
  logic [2:0]       src_wen;
  logic [2:0][4:0]  src_rd;
  logic [2:0][31:0] src_wdata;
  logic [2:0]       src_spec;
  logic             flush;
  logic             branch_resolved;
  logic             freeze;
  logic             wb_valid;
  logic [1:0]       wb_src;
  logic             wb_reg_en;
  logic [4:0]       wb_rd;
  logic [31:0]      s_wdata;
  logic [2:0]       fu_done;

  int checks   = 0;
  int failures = 0;

  wb_arbiter dut (
    .CLK             (CLK),
    .RST             (RST),
    .src_valid       (src_valid),
    .src_ready       (src_ready),
    .src_wen         (src_wen),
    .src_rd          (src_rd),
    .src_wdata       (src_wdata),
    .src_spec        (src_spec),
    .flush           (flush),
    .branch_resolved (branch_resolved),
    .freeze          (freeze),
    .wb_valid        (wb_valid),
    .wb_src          (wb_src),
    .wb_reg_en       (wb_reg_en),
    .wb_rd           (wb_rd),
    .s_wdata         (s_wdata),
    .fu_done         (fu_done)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic tick();
    @(negedge CLK);
  endtask

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic set_src(input logic [1:0] i, input logic v, input logic spec, input logic [4:0] rd);
    src_valid[i] = v;
    src_spec[i]  = spec;
    src_wen[i]   = 1'b1;
    src_rd[i]    = rd;
    src_wdata[i] = {24'hA5A5A5, 3'b000, rd};
  endtask

  task automatic idle_inputs();
    src_valid       = '0;
    src_wen         = '0;
    src_rd          = '0;
    src_wdata       = '0;
    src_spec        = '0;
    flush           = 1'b0;
    branch_resolved = 1'b0;
    freeze          = 1'b0;
  endtask

  task automatic do_reset();
    RST = 1'b1;
    idle_inputs();
    tick();
    RST = 1'b0;
  endtask

  initial begin
    RST = 1'b1;
    idle_inputs();
    tick();
    tick();
    // Reset state
    chk("rst_valid", 64'(wb_valid), 64'd0);
    chk("rst_done", 64'(fu_done), 64'd0);
    chk("rst_rd", 64'(wb_rd), 64'd0);
    chk("rst_wdata", 64'(s_wdata), 64'd0);
    chk("rst_src", 64'(wb_src), 64'd0);
    chk("rst_ready_hi", 64'(src_ready), 64'd0);
    RST = 1'b0;
    #1;
    chk("rst_ready_lo", 64'(src_ready), 64'b111);

    // Single ALU result, one-cycle latency, presented for one cycle
    tick();
    set_src(2'd0, 1'b1, 1'b0, 5'd5);
    src_wdata[0] = 32'hDEADBEEF;
    tick();
    idle_inputs();
    chk("alu_lat_valid", 64'(wb_valid), 64'd0);
    tick();
    chk("alu_valid", 64'(wb_valid), 64'd1);
    chk("alu_rd", 64'(wb_rd), 64'd5);
    chk("alu_wdata", 64'(s_wdata), 64'hDEADBEEF);
    chk("alu_done", 64'(fu_done), 64'b001);
    chk("alu_regen", 64'(wb_reg_en), 64'd1);
    chk("alu_src", 64'(wb_src), 64'd0);
    tick();
    chk("alu_clr_valid", 64'(wb_valid), 64'd0);
    chk("alu_clr_done", 64'(fu_done), 64'd0);
    chk("alu_clr_rd", 64'(wb_rd), 64'd0);
    chk("alu_clr_wdata", 64'(s_wdata), 64'd0);

    // Contention: all sources valid for 6 edges
    do_reset();
    set_src(2'd0, 1'b1, 1'b0, 5'd10);
    set_src(2'd1, 1'b1, 1'b0, 5'd11);
    set_src(2'd2, 1'b1, 1'b0, 5'd12);
    src_wen[2] = 1'b0;
    tick();
    chk("rr_first_valid", 64'(wb_valid), 64'd0);
    tick();
    chk("rr_src0", 64'(wb_src), 64'd0);
    chk("rr_ready0", 64'(src_ready), 64'b001);
    tick();
    chk("rr_src1", 64'(wb_src), 64'd1);
    chk("rr_ready1", 64'(src_ready), 64'b010);
    tick();
    chk("rr_src2", 64'(wb_src), 64'd2);
    chk("rr_ready2", 64'(src_ready), 64'b100);
    chk("rr_regen_nowen", 64'(wb_reg_en), 64'd0);
    chk("rr_rd2", 64'(wb_rd), 64'd12);
    chk("rr_done2", 64'(fu_done), 64'b100);
    tick();
    chk("rr_src3", 64'(wb_src), 64'd0);
    tick();
    chk("rr_src4", 64'(wb_src), 64'd1);
    idle_inputs();
    tick();
    chk("rr_src5", 64'(wb_src), 64'd2);
    repeat (8) tick();
    chk("rr_drain_valid", 64'(wb_valid), 64'd0);
    chk("rr_drain_ready", 64'(src_ready), 64'b111);

    // Freeze holds the output for three cycles, enqueue continues
    do_reset();
    set_src(2'd0, 1'b1, 1'b0, 5'd7);
    set_src(2'd1, 1'b1, 1'b0, 5'd8);
    tick();
    idle_inputs();
    tick();
    chk("frz_load_rd", 64'(wb_rd), 64'd7);
    freeze = 1'b1;
    tick();
    chk("frz_hold1_rd", 64'(wb_rd), 64'd7);
    chk("frz_hold1_valid", 64'(wb_valid), 64'd1);
    set_src(2'd2, 1'b1, 1'b0, 5'd9);
    tick();
    src_valid = '0;
    chk("frz_hold2_rd", 64'(wb_rd), 64'd7);
    chk("frz_hold2_done", 64'(fu_done), 64'b001);
    tick();
    chk("frz_hold3_rd", 64'(wb_rd), 64'd7);
    chk("frz_hold3_valid", 64'(wb_valid), 64'd1);
    freeze = 1'b0;
    tick();
    chk("frz_next_src", 64'(wb_src), 64'd1);
    chk("frz_next_rd", 64'(wb_rd), 64'd8);
    tick();
    chk("frz_enq_src", 64'(wb_src), 64'd2);
    chk("frz_enq_rd", 64'(wb_rd), 64'd9);
    tick();
    chk("frz_end_valid", 64'(wb_valid), 64'd0);

    // Flush: spec output dropped, LD/ST truncated to its non-spec head
    do_reset();
    set_src(2'd0, 1'b1, 1'b1, 5'd3);
    set_src(2'd1, 1'b1, 1'b0, 5'd1);
    tick();
    src_valid[0] = 1'b0;
    set_src(2'd1, 1'b1, 1'b1, 5'd2);
    tick();
    idle_inputs();
    chk("fl_out_rd", 64'(wb_rd), 64'd3);
    chk("fl_out_valid", 64'(wb_valid), 64'd1);
    flush = 1'b1;
    set_src(2'd2, 1'b1, 1'b1, 5'd6);
    #1;
    chk("fl_spec_ready", 64'(src_ready[2]), 64'd1);
    tick();
    idle_inputs();
    chk("fl_drop_valid", 64'(wb_valid), 64'd0);
    tick();
    chk("fl_keep_valid", 64'(wb_valid), 64'd1);
    chk("fl_keep_rd", 64'(wb_rd), 64'd1);
    chk("fl_keep_src", 64'(wb_src), 64'd1);
    tick();
    chk("fl_none1", 64'(wb_valid), 64'd0);
    tick();
    chk("fl_none2", 64'(wb_valid), 64'd0);

    // branch_resolved one cycle ahead of a flush saves the entry
    do_reset();
    set_src(2'd0, 1'b1, 1'b1, 5'd4);
    tick();
    idle_inputs();
    freeze          = 1'b1;
    branch_resolved = 1'b1;
    tick();
    branch_resolved = 1'b0;
    flush           = 1'b1;
    tick();
    flush  = 1'b0;
    freeze = 1'b0;
    chk("br_hold_valid", 64'(wb_valid), 64'd0);
    tick();
    chk("br_saved_valid", 64'(wb_valid), 64'd1);
    chk("br_saved_rd", 64'(wb_rd), 64'd4);

    // Reset with all FIFOs full and the pointer away from zero
    set_src(2'd0, 1'b1, 1'b0, 5'd20);
    set_src(2'd1, 1'b1, 1'b0, 5'd21);
    set_src(2'd2, 1'b1, 1'b0, 5'd22);
    freeze = 1'b1;
    tick();
    tick();
    chk("mr_full_ready", 64'(src_ready), 64'b000);
    RST = 1'b1;
    idle_inputs();
    tick();
    chk("mr_valid", 64'(wb_valid), 64'd0);
    chk("mr_done", 64'(fu_done), 64'd0);
    chk("mr_rd", 64'(wb_rd), 64'd0);
    chk("mr_ready_hi", 64'(src_ready), 64'b000);
    RST = 1'b0;
    #1;
    chk("mr_ready_lo", 64'(src_ready), 64'b111);
    set_src(2'd0, 1'b1, 1'b0, 5'd25);
    set_src(2'd1, 1'b1, 1'b0, 5'd26);
    set_src(2'd2, 1'b1, 1'b0, 5'd27);
    tick();
    idle_inputs();
    tick();
    chk("mr_first_src", 64'(wb_src), 64'd0);
    chk("mr_first_rd", 64'(wb_rd), 64'd25);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
